matvec_seq_ctrl: RTL and testbench
==================================

Name: matvec_seq_ctrl

Overview:
- Sequencing controller for the shared 64x64 int8 matrix-vector multiply engine.
- Loads an input vector over a valid/ready stream and holds it in a local buffer.
- Walks the weight memory row by row through a single MAC, saturates each row sum to int8, and streams results out with backpressure.
- Sits between the upstream vector producer, the external weight RAM and the downstream consumer. It replaces the fully parallel single-cycle datapath with a time-multiplexed one.

Parameters:
- N, 64, vector length and matrix dimension (rows = cols = N).
- DW, 8, element width, signed two's complement.
- ACC_W, 22, accumulator width. Must be at least 2*DW+clog2(N); no internal wrap is allowed.
- AW, 12, weight address width, clog2(N*N).

Ports:
- clk  in  1  clock.
- rstn  in  1  async active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  controller accepts input element.
- in_data  in  DW  signed input element, index order 0..N-1.
- w_rd_en  out  1  weight RAM read strobe.
- w_addr  out  AW  weight address = row*N + col.
- w_rdata  in  DW  signed weight, valid exactly 1 cycle after w_rd_en.
- out_valid  out  1  result element valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DW  saturated signed row result.
- out_last  out  1  high with out_valid on row N-1.
- busy  out  1  high in any state other than LOAD.

Behaviour:
- Reset is asynchronous and active-low on rstn; clock is clk. Reset state is LOAD.
  - Reset values: in_ready=1, w_rd_en=0, w_addr=0, out_valid=0, out_data=0, out_last=0, busy=0.
  - Reset also clears the row counter, column counter, load counter and accumulator.
- States: LOAD, ISSUE, DRAIN, OUT.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready edge writes in_data to vbuf[load_cnt] and increments load_cnt.
  - On acceptance of element N-1: go to ISSUE, with row=0 and col=0.
- ISSUE:
  - w_rd_en=1, w_addr=row*N+col; col increments each cycle.
  - Each edge accumulates acc += w_rdata*vbuf[col_d] for the read issued in the previous cycle. col_d is col delayed by one cycle; there is no accumulation on the first ISSUE cycle of a row.
  - After issuing col N-1: go to DRAIN.
- DRAIN:
  - w_rd_en=0.
  - At the exiting edge: out_data <= sat(acc + w_rdata*vbuf[N-1]), acc <= 0, out_valid <= 1, out_last <= (row==N-1). Then go to OUT.
- OUT:
  - out_valid and out_data are held stable until out_valid&&out_ready. No weight reads occur while waiting.
  - On handshake: out_valid <= 0. If row==N-1, go to LOAD (load_cnt=0). Otherwise row++, col=0, go to ISSUE.
- Latency:
  - Each row occupies exactly N ISSUE cycles plus 1 DRAIN cycle.
  - out_valid rises on the (N+1)th rising edge after the edge accepting the last input element, and after each non-final output handshake.
- Arithmetic:
  - Products are DW x DW signed into 2*DW bits, sign-extended to ACC_W.
  - Saturation: a value above 127 gives 127; below -128 gives -128; otherwise the low DW bits.
- in_ready=0 outside LOAD. in_valid is ignored outside LOAD.
- A new vector cannot be accepted until the final output handshake completes. There is no overlap between vectors.
- Reset mid-operation aborts immediately: the partial vector and accumulator are discarded, with no spurious out_valid.

Optional Feature:
- Macro MATVEC_SAT_CNT_EN.
- Defined:
  - Adds output port sat_cnt, width clog2(N)+1, reset 0.
  - Increments at each DRAIN exit where saturation clipped the result.
  - Clears on the edge accepting element 0 of the next vector.
- Undefined: no port and no counter logic.

Decomposition:
- matvec_pkg holds:
  - localparams N, DW, ACC_W, AW;
  - the state enum typedef (LOAD, ISSUE, DRAIN, OUT);
  - the function sat_to_dw(ACC_W to DW).
- Sub-module matvec_mac: signed multiply-accumulate with clear and accumulate-enable, exposing the next-sum value for the DRAIN saturation.

Test Plan:
- Vector all 1, weights all 1: every out_data=64; out_last only on the 64th output; first out_valid exactly 65 edges after the last input acceptance.
- Vector all 2, weights all 1 (sum 128): all outputs 127. Vector all -128, weights all 127: all outputs -128. With MATVEC_SAT_CNT_EN, sat_cnt=64 in both cases.
- Identity weights, v[j]=j-32: out[i]=i-32 for i=0..63, in order; with MATVEC_SAT_CNT_EN, sat_cnt=0.
- Hold out_ready=0 for 10 cycles on row 5: out_data stable, w_rd_en=0 throughout, row 6 starts ISSUE on the edge after the handshake.
- Assert in_valid continuously with random data during compute: in_ready=0, vbuf unchanged, results match the first vector.
- Pulse rstn low during ISSUE of row 20: all outputs at reset values immediately, in_ready=1 after release, next full vector produces correct 64 results.

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared parameters, FSM state type and saturation helpers for the
// time-multiplexed int8 matrix-vector sequencer.
package matvec_pkg;

  localparam int N     = 64;
  localparam int DW    = 8;
  localparam int ACC_W = 22;
  localparam int AW    = 12;
  localparam int CW    = $clog2(N);

  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic logic is_sat(input logic signed [ACC_W-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  function automatic logic signed [DW-1:0] sat_to_dw(input logic signed [ACC_W-1:0] v);
    if (v > SMAX)
      return {1'b0, {(DW-1){1'b1}}};
    else if (v < SMIN)
      return {1'b1, {(DW-1){1'b0}}};
    else
      return v[DW-1:0];
  endfunction

endpackage

// File: rtl/matvec_seq_ctrl_if.sv
// Input stream, weight-RAM read port and result stream of the sequencer.
// The slave modport is the controller's view, master is the surrounding system.
interface matvec_seq_ctrl_if;
  import matvec_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 w_rd_en;
  logic [AW-1:0]        w_addr;
  logic signed [DW-1:0] w_rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, w_rdata, out_ready,
    output in_ready, w_rd_en, w_addr, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, w_rdata, out_ready,
    input  in_ready, w_rd_en, w_addr, out_valid, out_data, out_last
  );

endinterface

// File: rtl/matvec_mac.sv
// Signed DW x DW multiply-accumulate; sum_nxt is the accumulator plus the
// current product so the final column can be folded in without a write-back.
module matvec_mac
  import matvec_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] sum_nxt
);

  logic signed [2*DW-1:0]  a_x, b_x, prod;
  logic signed [ACC_W-1:0] acc;

  assign a_x     = {{DW{a[DW-1]}}, a};
  assign b_x     = {{DW{b[DW-1]}}, b};
  assign prod    = a_x * b_x;
  assign sum_nxt = acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= sum_nxt;
  end

endmodule

// File: rtl/matvec_seq_ctrl.sv
// Sequencer: loads a vector, walks weight rows through one MAC, streams
// saturated row sums. Define MATVEC_SAT_CNT_EN to add the sat_cnt port.
//
// state | meaning
// LOAD  | accept input elements into vbuf
// ISSUE | one weight read per cycle for the current row
// DRAIN | fold last product, saturate, present result
// OUT   | hold result until downstream handshake
module matvec_seq_ctrl
  import matvec_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  matvec_seq_ctrl_if.slave  bus,
  output logic              busy
`ifdef MATVEC_SAT_CNT_EN
  ,
  output logic [CW:0]       sat_cnt
`endif
);

  state_t                  state, state_nxt;
  logic [CW-1:0]           load_cnt, row, col, col_d;
  logic                    rd_pend;
  logic signed [DW-1:0]    vbuf [N];
  logic signed [ACC_W-1:0] sum_nxt;
  logic                    in_fire, out_fire;

  assign in_fire      = bus.in_valid && (state == LOAD);
  assign out_fire     = bus.out_valid && bus.out_ready;
  assign bus.in_ready = (state == LOAD);
  assign bus.w_addr   = {row, col};
  assign busy         = (state != LOAD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= LOAD;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.w_rd_en = 1'b0;
    case (state)
      LOAD:  if (in_fire && load_cnt == CW'(N-1)) state_nxt = ISSUE;
      ISSUE: begin
        bus.w_rd_en = 1'b1;
        if (col == CW'(N-1)) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = OUT;
      OUT:   if (out_fire) state_nxt = (row == CW'(N-1)) ? LOAD : ISSUE;
      default: state_nxt = LOAD;
    endcase
  end

  // Vector storage is indexed by load_cnt, which reset clears, so no reset needed.
  always_ff @(posedge clk) begin
    if (in_fire)
      vbuf[load_cnt] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_cnt      <= '0;
      row           <= '0;
      col           <= '0;
      col_d         <= '0;
      rd_pend       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      col_d   <= col;
      rd_pend <= (state == ISSUE);
      case (state)
        LOAD: if (in_fire) begin
          load_cnt <= load_cnt + CW'(1);
          if (load_cnt == CW'(N-1)) begin
            row <= '0;
            col <= '0;
          end
        end
        ISSUE: col <= col + CW'(1);
        DRAIN: begin
          bus.out_data  <= sat_to_dw(sum_nxt);
          bus.out_valid <= 1'b1;
          bus.out_last  <= (row == CW'(N-1));
        end
        OUT: if (out_fire) begin
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
          if (row == CW'(N-1)) begin
            load_cnt <= '0;
          end else begin
            row <= row + CW'(1);
            col <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // The first ISSUE cycle of a row has no read in flight, so rd_pend gates it.
  matvec_mac u_mac (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (state == DRAIN),
    .en      ((state == ISSUE) && rd_pend),
    .a       (bus.w_rdata),
    .b       (vbuf[col_d]),
    .sum_nxt (sum_nxt)
  );

`ifdef MATVEC_SAT_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      sat_cnt <= '0;
    else if (in_fire && load_cnt == '0)
      sat_cnt <= '0;
    else if (state == DRAIN && is_sat(sum_nxt))
      sat_cnt <= sat_cnt + (CW+1)'(1);
  end
`endif

endmodule

// File: tb/tb_matvec_seq_ctrl.sv
// Directed bench for matvec_seq_ctrl: reset values, row sums, saturation,
// latency, output stall, ignored input during compute and mid-run reset.
module tb_matvec_seq_ctrl;
  import matvec_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy;
`ifdef MATVEC_SAT_CNT_EN
  logic [CW:0] sat_cnt;
`endif

  matvec_seq_ctrl_if bus ();

  matvec_seq_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .busy (busy)
`ifdef MATVEC_SAT_CNT_EN
    ,
    .sat_cnt (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int wmode = 0;
  int last_edge = 0;
  logic signed [DW-1:0] vec [N];

  // Weight RAM: mode 0 all ones, mode 1 all 127, mode 2 identity.
  function automatic logic signed [DW-1:0] wfun(input logic [AW-1:0] a);
    case (wmode)
      0: return DW'(1);
      1: return DW'(127);
      default: return (a[AW-1:CW] == a[CW-1:0]) ? DW'(1) : DW'(0);
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_rdata <= wfun(bus.w_addr);
  end

  // Hand-computed row results: 64*1*1, 64*2 clipped, 64*-128*127 clipped, identity.
  function automatic int exp_out(input int tid, input int i);
    case (tid)
      0: return 64;
      1: return 127;
      2: return -128;
      default: return i - 32;
    endcase
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic load_vec();
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = vec[j];
      if (j == 0) check("in_ready_load", int'(bus.in_ready), 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    last_edge = cyc;
  endtask

  task automatic run_vec(input int tid, input bit stall, input bit noise);
    logic signed [DW-1:0] d;
    load_vec();
    if (noise) bus.in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      int n = 0;
      while (!bus.out_valid && n < 300) begin
        @(negedge clk);
        n++;
        if (noise) bus.in_data = DW'($urandom);
      end
      if (!bus.out_valid) begin
        check("out_timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
      if (i < 2) check(i == 0 ? "lat_first" : "lat_next", cyc - last_edge, N + 1);
      check("out_data", int'(bus.out_data), exp_out(tid, i));
      check("out_last", int'(bus.out_last), int'(i == N - 1));
      if (noise && (i % 16) == 0) begin
        check("noise_in_ready", int'(bus.in_ready), 0);
        check("noise_busy", int'(busy), 1);
      end
      if (stall && i == 5) begin
        bus.out_ready = 1'b0;
        d = bus.out_data;
        repeat (10) begin
          @(negedge clk);
          check("stall_data", int'(bus.out_data), int'(d));
          check("stall_rd_en", int'(bus.w_rd_en), 0);
          check("stall_valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      last_edge = cyc;
      if (stall && i == 5) begin
        check("row6_rd_en", int'(bus.w_rd_en), 1);
        check("row6_addr", int'(bus.w_addr), 6 * N);
      end
      if (noise && i == N - 1) bus.in_valid = 1'b0;
    end
  endtask

  task automatic check_sat(input int exp);
`ifdef MATVEC_SAT_CNT_EN
    check("sat_cnt", int'(sat_cnt), exp);
`else
    if (exp < 0) check("sat_cnt_arg", exp, 0);
`endif
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_w_rd_en", int'(bus.w_rd_en), 0);
    check("rst_w_addr", int'(bus.w_addr), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_busy", int'(busy), 0);
    check_sat(0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rstn = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    wmode = 0;
    for (int j = 0; j < N; j++) vec[j] = DW'(1);
    run_vec(0, 1'b0, 1'b0);
    check_sat(0);

    for (int j = 0; j < N; j++) vec[j] = DW'(2);
    run_vec(1, 1'b0, 1'b0);
    check_sat(64);

    wmode = 1;
    for (int j = 0; j < N; j++) vec[j] = DW'(-128);
    run_vec(2, 1'b0, 1'b0);
    check_sat(64);

    wmode = 2;
    for (int j = 0; j < N; j++) vec[j] = DW'(j - 32);
    run_vec(3, 1'b1, 1'b0);
    check_sat(0);

    run_vec(3, 1'b0, 1'b1);
    check_sat(0);

    // Abort during row 20, then a fresh vector must come out clean.
    wmode = 0;
    for (int j = 0; j < N; j++) vec[j] = DW'(1);
    load_vec();
    begin
      int n = 0;
      while (!(bus.w_rd_en && bus.w_addr[AW-1:CW] == CW'(20)) && n < 3000) begin
        @(negedge clk);
        n++;
      end
    end
    check("row20_reached", int'(bus.w_rd_en), 1);
    rstn = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(bus.in_ready), 1);
    check("post_rst_valid", int'(bus.out_valid), 0);

    wmode = 2;
    for (int j = 0; j < N; j++) vec[j] = DW'(j - 32);
    run_vec(3, 1'b0, 1'b0);
    check_sat(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
